// File: rtl/vga_sync_gen_if.sv
// Bundle between the raster timing generator, the display block and the VGA pins.
// The generator is the master: it drives the raster position, strobes and pins and reads colour back.
interface vga_sync_gen_if;
    logic        red;
    logic        green;
    logic        blue;
    logic [31:0] col;
    logic [31:0] row;
    logic        vnotactive;
    logic        pix_en;
    logic        frame_start;
    logic        vga_hs_n;
    logic        vga_vs_n;
    logic        vga_r;
    logic        vga_g;
    logic        vga_b;

    modport master (
        input  red, green, blue,
        output col, row, vnotactive, pix_en, frame_start,
        output vga_hs_n, vga_vs_n, vga_r, vga_g, vga_b
    );

    modport slave (
        output red, green, blue,
        input  col, row, vnotactive, pix_en, frame_start,
        input  vga_hs_n, vga_vs_n, vga_r, vga_g, vga_b
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel divider, row/col counters, sync decode and a
// delay line that lines sync and blanking up with the registered colour from display.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter int PIPE_DLY = 1
) (
    input  logic           CLK,
    input  logic           RST,
    vga_sync_gen_if.master bus
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [31:0]      col_q, col_d;
    logic [31:0]      row_q, row_d;
    logic             pix_en_q, pix_en_d;
    logic             frame_start_q, frame_start_d;
    logic             adv;

    // pix_en and frame_start are registered alongside the counters, so each strobe
    // is high in exactly the cycle the new position becomes visible.
    always_comb begin
        adv           = (div_q == DIV_LAST);
        div_d         = adv ? '0 : div_q + DIV_W'(1);
        col_d         = col_q;
        row_d         = row_q;
        pix_en_d      = adv;
        frame_start_d = 1'b0;
        if (adv) begin
            if (col_q >= 32'(H_TOTAL - 1)) begin
                col_d = '0;
                if (row_q >= 32'(V_TOTAL - 1)) begin
                    row_d         = '0;
                    frame_start_d = 1'b1;
                end else begin
                    row_d = row_q + 32'd1;
                end
            end else begin
                col_d = col_q + 32'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_q         <= '0;
            col_q         <= '0;
            row_q         <= '0;
            pix_en_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            col_q         <= col_d;
            row_q         <= row_d;
            pix_en_q      <= pix_en_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Raw decode packed as {hsync, vsync, de}, all active-high.
    logic [2:0] raw;
    logic [2:0] tap;

    always_comb begin
        raw[2] = (col_q >= 32'(HS_START)) && (col_q < 32'(HS_END));
        raw[1] = (row_q >= 32'(VS_START)) && (row_q < 32'(VS_END));
        raw[0] = (col_q < 32'(H_ACTIVE)) && (row_q < 32'(V_ACTIVE));
    end

    generate
        if (PIPE_DLY == 0) begin : g_no_dly
            assign tap = raw;
        end else begin : g_dly
            logic [2:0] sr_q [PIPE_DLY];
            logic [2:0] sr_d [PIPE_DLY];

            always_comb begin
                sr_d[0] = raw;
                for (int i = 1; i < PIPE_DLY; i++) begin
                    sr_d[i] = sr_q[i-1];
                end
            end

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    for (int i = 0; i < PIPE_DLY; i++) begin
                        sr_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < PIPE_DLY; i++) begin
                        sr_q[i] <= sr_d[i];
                    end
                end
            end

            assign tap = sr_q[PIPE_DLY-1];
        end
    endgenerate

    logic       hs_n_q, hs_n_d;
    logic       vs_n_q, vs_n_d;
    logic [2:0] rgb_q, rgb_d;

    always_comb begin
        hs_n_d = ~tap[2];
        vs_n_d = ~tap[1];
        rgb_d  = tap[0] ? {bus.red, bus.green, bus.blue} : 3'b000;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hs_n_q <= 1'b1;
            vs_n_q <= 1'b1;
            rgb_q  <= 3'b000;
        end else begin
            hs_n_q <= hs_n_d;
            vs_n_q <= vs_n_d;
            rgb_q  <= rgb_d;
        end
    end

    assign bus.col         = col_q;
    assign bus.row         = row_q;
    assign bus.vnotactive  = (row_q >= 32'(V_ACTIVE));
    assign bus.pix_en      = pix_en_q;
    assign bus.frame_start = frame_start_q;
    assign bus.vga_hs_n    = hs_n_q;
    assign bus.vga_vs_n    = vs_n_q;
    assign bus.vga_r       = rgb_q[2];
    assign bus.vga_g       = rgb_q[1];
    assign bus.vga_b       = rgb_q[0];
endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default-timing instance for reset and line timing, plus a tiny
// raster (16x10, CLK_DIV=1, PIPE_DLY=0) for frame timing, blanking and mid-frame reset.
module tb_vga_sync_gen;
    logic clk = 1'b0;
    logic rst_def;
    logic rst_sml;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    vga_sync_gen_if bus_def ();
    vga_sync_gen_if bus_sml ();

    vga_sync_gen u_def (
        .CLK (clk),
        .RST (rst_def),
        .bus (bus_def)
    );

    vga_sync_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .CLK_DIV  (1), .PIPE_DLY (0)
    ) u_sml (
        .CLK (clk),
        .RST (rst_sml),
        .bus (bus_sml)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    function automatic logic [2:0] rgb_of(input bit sml);
        return sml ? {bus_sml.vga_r, bus_sml.vga_g, bus_sml.vga_b}
                   : {bus_def.vga_r, bus_def.vga_g, bus_def.vga_b};
    endfunction

    // Waits for a cycle showing a freshly advanced position (r,c); r<0 means any row.
    task automatic wait_pos(input bit sml, input int r, input int c, input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sml) begin
                if (bus_sml.pix_en && bus_sml.col == 32'(c) && (r < 0 || bus_sml.row == 32'(r))) begin
                    to = 1'b0;
                    break;
                end
            end else begin
                if (bus_def.pix_en && bus_def.col == 32'(c) && (r < 0 || bus_def.row == 32'(r))) begin
                    to = 1'b0;
                    break;
                end
            end
        end
    endtask

    initial begin
        bit to;
        int linelen, pixcnt, hlow, tfall, t656, t700, rgb7;
        logic [2:0] rgb700, rgb_k1, rgb_k129;
        int fs_cnt, vn_cnt, vs_low, vs_first, max_row, max_col;

        rst_def = 1'b1;
        rst_sml = 1'b1;
        bus_def.red = 1'b1; bus_def.green = 1'b1; bus_def.blue = 1'b1;
        bus_sml.red = 1'b1; bus_sml.green = 1'b1; bus_sml.blue = 1'b1;

        // Reset values with the clock running
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_col",    bus_def.col, 0);
        check("rst_row",    bus_def.row, 0);
        check("rst_pix_en", bus_def.pix_en, 0);
        check("rst_fs",     bus_def.frame_start, 0);
        check("rst_hs_n",   bus_def.vga_hs_n, 1);
        check("rst_vs_n",   bus_def.vga_vs_n, 1);
        check("rst_rgb",    rgb_of(0), 0);
        check("rst_vnot",   bus_def.vnotactive, 0);
        rst_def = 1'b0;
        rst_sml = 1'b0;

        @(negedge clk);
        check("edge1_pix_en", bus_def.pix_en, 0);
        check("edge1_col",    bus_def.col, 0);
        check("edge1_fs",     bus_def.frame_start, 0);
        @(negedge clk);
        check("edge2_pix_en", bus_def.pix_en, 1);
        check("edge2_col",    bus_def.col, 1);
        check("edge2_rgb",    rgb_of(0), 3'b111);
        @(negedge clk);
        check("edge3_pix_en", bus_def.pix_en, 0);

        // One full default line, row 1
        wait_pos(0, -1, 0, 2000, to);
        check("def_wrap1_timeout", to, 0);
        check("def_wrap1_row", bus_def.row, 1);
        linelen = -1; pixcnt = 0; hlow = 0; tfall = -1; t656 = -1; t700 = -1; rgb7 = 0;
        rgb700 = 3'b101;
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            if (bus_def.pix_en) pixcnt++;
            if (!bus_def.vga_hs_n) begin
                hlow++;
                if (tfall < 0) tfall = k;
            end
            if (bus_def.pix_en && bus_def.col == 656 && t656 < 0) t656 = k;
            if (bus_def.pix_en && bus_def.col == 700) t700 = k;
            if (t700 > 0 && k == t700 + 2) rgb700 = rgb_of(0);
            if (rgb_of(0) == 3'b111) rgb7++;
            if (bus_def.pix_en && bus_def.col == 0) begin
                linelen = k;
                break;
            end
        end
        check("def_line_clk",     linelen, 1600);
        check("def_line_pix",     pixcnt, 800);
        check("def_hs_low_clk",   hlow, 192);
        check("def_hs_fall_dly",  tfall - t656, 2);
        check("def_rgb_on_clk",   rgb7, 1280);
        check("def_rgb_col700",   rgb700, 0);
        check("def_wrap2_row",    bus_def.row, 2);

        // Small raster: fresh reset, then line checks
        rst_sml = 1'b1;
        #1;
        check("sml_async_col", bus_sml.col, 0);
        repeat (2) @(negedge clk);
        rst_sml = 1'b0;
        @(negedge clk);
        check("sml_edge1_col",    bus_sml.col, 1);
        check("sml_edge1_pix_en", bus_sml.pix_en, 1);

        wait_pos(1, -1, 0, 100, to);
        check("sml_wrap_timeout", to, 0);
        linelen = -1; pixcnt = 0; hlow = 0; tfall = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus_sml.pix_en) pixcnt++;
            if (!bus_sml.vga_hs_n) begin
                hlow++;
                if (tfall < 0) tfall = k;
            end
            if (bus_sml.col == 0) begin
                linelen = k;
                break;
            end
        end
        check("sml_line_clk",   linelen, 16);
        check("sml_line_pix",   pixcnt, 16);
        check("sml_hs_low_clk", hlow, 3);
        check("sml_hs_fall_at", tfall, 11);

        // One full small frame starting at a frame_start pulse
        to = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus_sml.frame_start) begin
                to = 1'b0;
                break;
            end
        end
        check("sml_fs_timeout", to, 0);
        check("sml_fs_row", bus_sml.row, 0);
        check("sml_fs_col", bus_sml.col, 0);
        pixcnt = 0; fs_cnt = 0; vn_cnt = 0; vs_low = 0; vs_first = -1; rgb7 = 0;
        max_row = 0; max_col = 0; rgb_k1 = 3'b010; rgb_k129 = 3'b010;
        for (int k = 0; k < 160; k++) begin
            if (k > 0) @(negedge clk);
            if (bus_sml.pix_en) pixcnt++;
            if (bus_sml.frame_start) fs_cnt++;
            if (bus_sml.vnotactive) vn_cnt++;
            if (!bus_sml.vga_vs_n) begin
                vs_low++;
                if (vs_first < 0) vs_first = k;
            end
            if (rgb_of(1) == 3'b111) rgb7++;
            if (k == 1) rgb_k1 = rgb_of(1);
            if (k == 129) rgb_k129 = rgb_of(1);
            if (int'(bus_sml.row) > max_row) max_row = int'(bus_sml.row);
            if (int'(bus_sml.col) > max_col) max_col = int'(bus_sml.col);
        end
        @(negedge clk);
        check("sml_fs_period",    bus_sml.frame_start, 1);
        check("sml_fs_count",     fs_cnt, 1);
        check("sml_pix_always",   pixcnt, 160);
        check("sml_vnot_clk",     vn_cnt, 64);
        check("sml_vs_low_clk",   vs_low, 32);
        check("sml_vs_fall_at",   vs_first, 113);
        check("sml_rgb_on_clk",   rgb7, 48);
        check("sml_rgb_row0col0", rgb_k1, 3'b111);
        check("sml_rgb_row8",     rgb_k129, 0);
        check("sml_max_row",      max_row, 9);
        check("sml_max_col",      max_col, 15);

        // Reset while both syncs are asserted
        wait_pos(1, 7, 11, 200, to);
        check("sml_mid_timeout", to, 0);
        check("sml_mid_hs_before", bus_sml.vga_hs_n, 0);
        rst_sml = 1'b1;
        #1;
        check("sml_mid_rst_col",  bus_sml.col, 0);
        check("sml_mid_rst_row",  bus_sml.row, 0);
        check("sml_mid_rst_hs_n", bus_sml.vga_hs_n, 1);
        check("sml_mid_rst_vs_n", bus_sml.vga_vs_n, 1);
        @(negedge clk);
        rst_sml = 1'b0;
        @(negedge clk);
        check("sml_post_col",  bus_sml.col, 1);
        check("sml_post_row",  bus_sml.row, 0);
        check("sml_post_fs",   bus_sml.frame_start, 0);
        check("sml_post_hs_n", bus_sml.vga_hs_n, 1);
        check("sml_post_vs_n", bus_sml.vga_vs_n, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
